// File: rtl/ysyx_25040129_scoreboard_pkg.sv
// Shared constants and types for the issue scoreboard.
// Register-index width, pending-counter geometry and the source-hazard helper.
package ysyx_25040129_scoreboard_pkg;

    localparam int unsigned REGS_DIG = 4;
    localparam int unsigned CSR_DIG  = 12;
    localparam int unsigned NReg     = 1 << REGS_DIG;
    localparam int unsigned CntW     = 2;
    localparam int unsigned CntMax   = 3;

    typedef logic [REGS_DIG-1:0] reg_idx_t;
    typedef logic [CntW-1:0]     cnt_t;

    // A single outstanding write that retires this cycle is served by the WBU forward path.
    function automatic logic src_hazard(logic used, reg_idx_t idx, cnt_t cnt,
                                        logic wb_we, reg_idx_t wb_rd);
        logic fwd;
        fwd = (cnt == cnt_t'(1)) && wb_we && (wb_rd == idx);
        return used && (idx != '0) && (cnt != '0) && !fwd;
    endfunction

endpackage

// File: rtl/ysyx_25040129_scoreboard_if.sv
// Issue / writeback / status bundle between IDU-side logic and the scoreboard.
interface ysyx_25040129_scoreboard_if;
    import ysyx_25040129_scoreboard_pkg::*;

    logic            issue_valid;
    logic            issue_ready;
    reg_idx_t        issue_rs1;
    reg_idx_t        issue_rs2;
    logic            issue_rs1_used;
    logic            issue_rs2_used;
    reg_idx_t        issue_rd;
    logic            issue_reg_write;
    logic            issue_csr_write;
    logic            issue_csr_access;
    logic            wb_reg_write;
    reg_idx_t        wb_rd;
    logic            wb_csr_write;
    logic            flush;
    logic [NReg-1:0] busy_vec;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
               issue_rd, issue_reg_write, issue_csr_write, issue_csr_access,
               wb_reg_write, wb_rd, wb_csr_write, flush,
        input  issue_ready, busy_vec
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
               issue_rd, issue_reg_write, issue_csr_write, issue_csr_access,
               wb_reg_write, wb_rd, wb_csr_write, flush,
        output issue_ready, busy_vec
    );

endinterface

// File: rtl/ysyx_25040129_sb_counter.sv
// Saturating 2-bit pending-write counter; coincident inc/dec cancel, dec at zero is dropped.
module ysyx_25040129_sb_counter
    import ysyx_25040129_scoreboard_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    input  logic dec_i,
    output cnt_t cnt_o
);

    cnt_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i) begin
            if (cnt_q != cnt_t'(CntMax)) cnt_d = cnt_q + cnt_t'(1);
        end else if (dec_i && !inc_i) begin
            if (cnt_q != '0) cnt_d = cnt_q - cnt_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ysyx_25040129_scoreboard.sv
// In-order issue scoreboard: per-GPR and CSR pending-write counters gating IDU->EXU issue.
module ysyx_25040129_scoreboard
    import ysyx_25040129_scoreboard_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    ysyx_25040129_scoreboard_if.slave   sb_io
);

    cnt_t cnt [NReg];
    cnt_t csr_cnt;
    logic fire;
    logic rs1_haz, rs2_haz, rd_full, csr_stall;

    assign cnt[0] = '0;

    for (genvar i = 1; i < NReg; i++) begin : g_gpr
        ysyx_25040129_sb_counter u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (sb_io.flush),
            .inc_i (fire && sb_io.issue_reg_write && (sb_io.issue_rd == reg_idx_t'(i))),
            .dec_i (sb_io.wb_reg_write && (sb_io.wb_rd == reg_idx_t'(i))),
            .cnt_o (cnt[i])
        );
    end

    ysyx_25040129_sb_counter u_csr_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (sb_io.flush),
        .inc_i (fire && sb_io.issue_csr_write),
        .dec_i (sb_io.wb_csr_write),
        .cnt_o (csr_cnt)
    );

    always_comb begin
        rs1_haz = src_hazard(sb_io.issue_rs1_used, sb_io.issue_rs1, cnt[sb_io.issue_rs1],
                             sb_io.wb_reg_write, sb_io.wb_rd);
        rs2_haz = src_hazard(sb_io.issue_rs2_used, sb_io.issue_rs2, cnt[sb_io.issue_rs2],
                             sb_io.wb_reg_write, sb_io.wb_rd);
        // Full counter stalls even if a writeback frees a slot this cycle.
        rd_full = sb_io.issue_reg_write && (sb_io.issue_rd != '0) &&
                  (cnt[sb_io.issue_rd] == cnt_t'(CntMax));
        csr_stall = (sb_io.issue_csr_access && (csr_cnt != '0) &&
                     !((csr_cnt == cnt_t'(1)) && sb_io.wb_csr_write)) ||
                    (sb_io.issue_csr_write && (csr_cnt == cnt_t'(CntMax)));
        sb_io.issue_ready = !(rs1_haz || rs2_haz || rd_full || csr_stall ||
                              sb_io.flush || rst_i);
        fire = sb_io.issue_valid && sb_io.issue_ready;
    end

    always_comb begin
        sb_io.busy_vec = '0;
        for (int i = 0; i < NReg; i++) begin
            sb_io.busy_vec[i] = (cnt[i] != '0);
        end
    end

endmodule

// File: tb/tb_ysyx_25040129_scoreboard.sv
// Directed self-checking bench for the issue scoreboard.
module tb_ysyx_25040129_scoreboard;
    import ysyx_25040129_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    ysyx_25040129_scoreboard_if sb ();

    ysyx_25040129_scoreboard dut (
        .clk_i (clk),
        .rst_i (rst),
        .sb_io (sb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        sb.issue_valid = 0; sb.issue_rs1 = '0; sb.issue_rs2 = '0;
        sb.issue_rs1_used = 0; sb.issue_rs2_used = 0; sb.issue_rd = '0;
        sb.issue_reg_write = 0; sb.issue_csr_write = 0; sb.issue_csr_access = 0;
        sb.wb_reg_write = 0; sb.wb_rd = '0; sb.wb_csr_write = 0; sb.flush = 0;
    endtask

    task automatic wr(input int rd);
        sb.issue_valid = 1; sb.issue_reg_write = 1; sb.issue_rd = reg_idx_t'(rd);
    endtask

    task automatic rd2(input int a, input int b);
        sb.issue_valid = 1; sb.issue_rs1 = reg_idx_t'(a); sb.issue_rs2 = reg_idx_t'(b);
        sb.issue_rs1_used = 1; sb.issue_rs2_used = 1;
    endtask

    task automatic wb(input int rd);
        sb.wb_reg_write = 1; sb.wb_rd = reg_idx_t'(rd);
    endtask

    // Advance one edge; inputs change 1 time unit after it, checks 1 unit after that.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rd2(1, 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1;
        chk("reset_ready_low", sb.issue_ready, 0);
        chk("reset_busy_zero", sb.busy_vec, 0);
        rst = 0;
        #1;
        chk("post_reset_ready", sb.issue_ready, 1);

        // RAW on x5
        idle(); wr(5); #1;
        chk("addi_x5_ready", sb.issue_ready, 1);
        tick();
        rd2(5, 1); wr(6); #1;
        chk("raw_x5_stall", sb.issue_ready, 0);
        chk("raw_x5_busy", sb.busy_vec, 32'h0020);
        tick();
        rd2(5, 1); wr(6); wb(5); #1;
        chk("wb_forward_ready", sb.issue_ready, 1);
        tick(); #1;
        chk("x5_cleared_x6_busy", sb.busy_vec, 32'h0040);
        wb(6);
        tick(); #1;
        chk("x6_drained", sb.busy_vec, 0);

        // Saturation on x7
        for (int i = 0; i < 3; i++) begin
            wr(7); #1;
            chk("x7_fill_ready", sb.issue_ready, 1);
            tick();
        end
        wr(7); wb(7); #1;
        chk("x7_full_stall", sb.issue_ready, 0);
        tick();
        wr(7); #1;
        chk("x7_after_wb_ready", sb.issue_ready, 1);
        chk("x7_busy", sb.busy_vec, 32'h0080);
        idle(); wb(7); tick(); wb(7); tick(); #1;
        chk("x7_drained", sb.busy_vec, 0);

        // x0 never busy; decrement at zero ignored
        wr(0); #1;
        chk("x0_write_ready", sb.issue_ready, 1);
        tick();
        rd2(0, 0); #1;
        chk("x0_read_ready", sb.issue_ready, 1);
        chk("x0_busy_zero", sb.busy_vec, 0);
        idle(); wb(4); tick(); #1;
        chk("dec_at_zero", sb.busy_vec, 0);

        // Coincident inc/dec leaves count at 1
        wr(3); tick();
        wr(3); wb(3); tick();
        rd2(3, 0); #1;
        chk("incdec_still_busy", sb.issue_ready, 0);
        rd2(3, 0); wb(3); #1;
        chk("incdec_count_one", sb.issue_ready, 1);
        tick(); #1;
        chk("incdec_drained", sb.busy_vec, 0);

        // CSR ordering
        sb.issue_valid = 1; sb.issue_csr_write = 1; sb.issue_csr_access = 1; #1;
        chk("csrrw_ready", sb.issue_ready, 1);
        tick();
        sb.issue_valid = 1; sb.issue_csr_access = 1; #1;
        chk("csrr_stall", sb.issue_ready, 0);
        tick();
        sb.issue_valid = 1; sb.issue_csr_access = 1; #1;
        chk("csrr_stall_hold", sb.issue_ready, 0);
        sb.wb_csr_write = 1; #1;
        chk("csrr_wb_ready", sb.issue_ready, 1);
        tick();
        sb.issue_valid = 1; sb.issue_csr_access = 1; #1;
        chk("csr_pending_zero", sb.issue_ready, 1);
        idle();
        for (int i = 0; i < 3; i++) begin
            sb.issue_valid = 1; sb.issue_csr_write = 1; tick();
        end
        sb.issue_valid = 1; sb.issue_csr_write = 1; sb.wb_csr_write = 1; #1;
        chk("csr_full_stall", sb.issue_ready, 0);

        // Flush with concurrent fire
        idle(); sb.flush = 1; tick();
        wr(3); tick(); wr(3); tick(); wr(9); tick(); #1;
        chk("pre_flush_busy", sb.busy_vec, 32'h0208);
        wr(3); sb.flush = 1; #1;
        chk("flush_ready_low", sb.issue_ready, 0);
        tick(); #1;
        chk("flush_busy_zero", sb.busy_vec, 0);
        rd2(3, 9); sb.issue_csr_access = 1; #1;
        chk("flush_reader_ready", sb.issue_ready, 1);

        // Reset mid-operation
        idle();
        wr(3); tick(); wr(3); tick(); wr(9); tick(); #1;
        chk("pre_reset_busy", sb.busy_vec, 32'h0208);
        rst = 1; wr(3); #1;
        chk("reset_mid_ready_low", sb.issue_ready, 0);
        tick(); rst = 0; #1;
        chk("reset_mid_busy_zero", sb.busy_vec, 0);
        rd2(3, 9); wr(9); #1;
        chk("reset_mid_reader_ready", sb.issue_ready, 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
